fifo_stream_drain: RTL

- Read-side consumer placed directly downstream of synchronous_fifo.
- Pulls words from the FIFO and absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer.
- Presents the words as a valid/ready stream that is grouped into bursts, with m_last marking burst ends.
- Supports a flush request that stops reading and drains the buffered words before acknowledging.

---
 rtl/fifo_stream_drain_if.sv | 25 ++
 rtl/fifo_stream_drain.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain_if.sv
// Signal bundle between synchronous_fifo read side, fifo_stream_drain and the
// downstream stream consumer. master = fifo_stream_drain, slave = its environment.
interface fifo_stream_drain_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic                  flush;
   logic                  flush_done;

   modport master (
      input  fifo_empty, fifo_data, m_ready, flush,
      output fifo_rd_en, m_valid, m_data, m_last, flush_done
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready, flush,
      input  fifo_rd_en, m_valid, m_data, m_last, flush_done
   );
endinterface

// File: rtl/fifo_stream_drain.sv
// Drains synchronous_fifo into a burst-framed valid/ready stream via a 3-entry skid buffer.
// Define FIFO_STREAM_DRAIN_STATS_EN to add the word_count handshake counter port.
module fifo_stream_drain #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_stream_drain_if.master  bus
`ifdef FIFO_STREAM_DRAIN_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] word_count
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0]  beat_q, beat_d;
   logic                  flush_done_q, flush_done_d;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] skid_q [3];
   logic [DATA_WIDTH-1:0] skid_d [3];

   logic       rd_en;
   logic       pop;
   logic       last;
   logic       drained;
   logic [1:0] occ_mid;

   // Credit counts buffered words plus the read still in flight, so a capture never overflows.
   always_comb begin
      rd_en   = (state_q == RUN) && !bus.fifo_empty &&
                (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
      last    = (occ_q != 2'd0) && (beat_q == CNT_WIDTH'(BURST_LEN - 1));
      pop     = (occ_q != 2'd0) && bus.m_ready;
      drained = (occ_q == 2'd0) && !inflight_q;
   end

   always_comb begin
      skid_d     = skid_q;
      occ_mid    = occ_q - {1'b0, pop};
      inflight_d = rd_en;
      if (pop) begin
         skid_d[0] = skid_q[1];
         skid_d[1] = skid_q[2];
      end
      if (inflight_q) begin
         for (int unsigned i = 0; i < 3; i++) begin
            if (occ_mid == 2'(i)) skid_d[i] = bus.fifo_data;
         end
      end
      occ_d = occ_mid + {1'b0, inflight_q};
   end

   // ack_q remembers an acknowledged flush so a held flush level yields one pulse only.
   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      beat_d       = beat_q;
      if (pop) beat_d = last ? '0 : beat_q + CNT_WIDTH'(1);
      case (state_q)
         IDLE: begin
            if (!bus.flush) state_d = RUN;
            else            flush_done_d = !ack_q;
         end
         RUN: begin
            if (bus.flush) state_d = DRAIN;
         end
         DRAIN: begin
            if (drained) begin
               flush_done_d = 1'b1;
               beat_d       = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ack_d = bus.flush && (ack_q || flush_done_d);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         occ_q        <= '0;
         inflight_q   <= 1'b0;
         beat_q       <= '0;
         flush_done_q <= 1'b0;
         ack_q        <= 1'b0;
         for (int unsigned i = 0; i < 3; i++) skid_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         occ_q        <= occ_d;
         inflight_q   <= inflight_d;
         beat_q       <= beat_d;
         flush_done_q <= flush_done_d;
         ack_q        <= ack_d;
         skid_q       <= skid_d;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (occ_q != 2'd0);
   assign bus.m_data     = skid_q[0];
   assign bus.m_last     = last;
   assign bus.flush_done = flush_done_q;

`ifdef FIFO_STREAM_DRAIN_STATS_EN
   logic [CNT_WIDTH-1:0] word_count_q, word_count_d;

   always_comb word_count_d = word_count_q + CNT_WIDTH'(pop);

   always_ff @(posedge clk) begin
      if (!reset) word_count_q <= '0;
      else        word_count_q <= word_count_d;
   end

   assign word_count = word_count_q;
`endif

endmodule
